// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Small program memory that is filled by a streaming loader source and read
//   by a processor fetch port. A load is started by load_start, words are
//   accepted through a valid/ready handshake, and the processor is held off
//   while the load is running. Outside a load the memory acts as a
//   registered-output instruction ROM with a 1-cycle read latency.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   load_start    : begin or restart a program load
//   wr_data       : instruction word from the loader source
//   wr_valid      : wr_data is valid
//   wr_ready      : block accepts wr_data this cycle (registered)
//   address       : processor fetch address
//   instruction   : registered fetch data (NOP while loading)
//   cpu_hold      : processor must not advance (registered)
//   load_done     : one-cycle pulse when a load completes (registered)
//   words_loaded  : words written in the current or most recent load
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] address,
  output logic [DW-1:0] instruction,
  output logic          cpu_hold,
  output logic          load_done,
  output logic [AW:0]   words_loaded
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] words_loaded_q, words_loaded_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] instruction_q, instruction_d;
  logic          wr_ready_q, wr_ready_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;

  // Next-state, memory write and registered-output decode
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    words_loaded_d = words_loaded_q;
    mem_d          = mem_q;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d        = LOAD;
          ptr_d          = '0;
          words_loaded_d = '0;
        end
      end
      LOAD: begin
        // A restart wins over a write offered in the same cycle
        if (load_start) begin
          ptr_d          = '0;
          words_loaded_d = '0;
        end else if (wr_valid && wr_ready_q) begin
          mem_d[ptr_q]   = wr_data;
          ptr_d          = ptr_q + AW'(1);
          words_loaded_d = words_loaded_q + CW'(1);
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake and hold flags are registered copies of the next state so
    // they line up with state_q and have no combinational input path
    wr_ready_d  = (state_d == LOAD);
    cpu_hold_d  = (state_d != IDLE);
    load_done_d = (state_d == DONE);

    // Fetch only while idle; writes never happen in IDLE so no bypass
    instruction_d = (state_q == IDLE) ? mem_q[address] : '0;
  end

  // State, pointer and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      words_loaded_q <= '0;
      instruction_q  <= '0;
      wr_ready_q     <= 1'b0;
      cpu_hold_q     <= 1'b0;
      load_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      words_loaded_q <= words_loaded_d;
      instruction_q  <= instruction_d;
      wr_ready_q     <= wr_ready_d;
      cpu_hold_q     <= cpu_hold_d;
      load_done_q    <= load_done_d;
    end
  end

  // Program memory, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign wr_ready     = wr_ready_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign instruction  = instruction_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Scoreboard bench for program_loader. Each driven cycle runs a behavioural
//   model of the loader and queues the outputs expected after the next rising
//   edge; a monitor pops and compares them. Directed scenarios come first,
//   then randomized traffic with occasional resets.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 8;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;

  typedef struct {
    logic [DW-1:0] instr;
    logic          rdy;
    logic          hold;
    logic          done;
    logic [AW:0]   wl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] address;
  logic [DW-1:0] instruction;
  logic          cpu_hold;
  logic          load_done;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model state
  int            m_mode;
  int            m_cnt;
  logic [DW-1:0] m_mem [DEPTH];

  program_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .address      (address),
    .instruction  (instruction),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cnt  = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // One clock edge of the loader described in terms of a word count
  task automatic model_step(input logic ls, input logic wv, input logic [DW-1:0] wd,
                            input logic [AW-1:0] a, output exp_t e);
    e.instr = (m_mode == M_IDLE) ? m_mem[a] : '0;
    if (m_mode == M_IDLE) begin
      if (ls) begin
        m_mode = M_LOAD;
        m_cnt  = 0;
      end
    end else if (m_mode == M_LOAD) begin
      if (ls) begin
        m_cnt = 0;
      end else if (wv) begin
        m_mem[m_cnt] = wd;
        m_cnt++;
        if (m_cnt == DEPTH) m_mode = M_DONE;
      end
    end else begin
      m_mode = M_IDLE;
    end
    e.rdy  = (m_mode == M_LOAD);
    e.hold = (m_mode != M_IDLE);
    e.done = (m_mode == M_DONE);
    e.wl   = (AW+1)'(m_cnt);
  endtask

  task automatic cycle(input logic ls, input logic wv, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a);
    exp_t e;
    @(negedge clk);
    rst_n      = 1'b1;
    load_start = ls;
    wr_valid   = wv;
    wr_data    = wd;
    address    = a;
    model_step(ls, wv, wd, a, e);
    exp_q.push_back(e);
  endtask

  // Assert reset between edges and check outputs clear immediately
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_instruction", int'(instruction), 0);
    check("rst_wr_ready", int'(wr_ready), 0);
    check("rst_cpu_hold", int'(cpu_hold), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_words_loaded", int'(words_loaded), 0);
    model_reset();
  endtask

  // Monitor: compare DUT outputs after each edge against queued expectations
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("instruction", int'(instruction), int'(e.instr));
      check("wr_ready", int'(wr_ready), int'(e.rdy));
      check("cpu_hold", int'(cpu_hold), int'(e.hold));
      check("load_done", int'(load_done), int'(e.done));
      check("words_loaded", int'(words_loaded), int'(e.wl));
    end
  end

  initial begin
    logic [DW-1:0] d;
    rst_n      = 1'b0;
    load_start = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = '0;
    address    = '0;
    model_reset();
    #3;
    check("init_instruction", int'(instruction), 0);
    check("init_wr_ready", int'(wr_ready), 0);
    check("init_cpu_hold", int'(cpu_hold), 0);
    check("init_load_done", int'(load_done), 0);
    check("init_words_loaded", int'(words_loaded), 0);

    // Reset then read address 2
    cycle(0, 0, 8'h00, 2'd2);
    cycle(0, 0, 8'h00, 2'd2);

    // Full load 0x11..0x44, then read back
    cycle(1, 0, 8'h00, 2'd0);
    cycle(0, 1, 8'h11, 2'd0);
    cycle(0, 1, 8'h22, 2'd0);
    cycle(0, 1, 8'h33, 2'd0);
    cycle(0, 1, 8'h44, 2'd0);
    cycle(0, 1, 8'h55, 2'd0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, (AW)'(i));
    cycle(0, 0, 8'h00, 2'd3);

    // Stalled source, then a load_start ignored in DONE
    cycle(1, 0, 8'h00, 2'd1);
    cycle(0, 1, 8'hA1, 2'd1);
    cycle(0, 0, 8'hA2, 2'd1);
    cycle(0, 0, 8'hA3, 2'd1);
    cycle(0, 1, 8'hA4, 2'd1);
    cycle(0, 0, 8'h00, 2'd1);
    cycle(0, 1, 8'hA5, 2'd1);
    cycle(0, 1, 8'hA6, 2'd1);
    cycle(1, 1, 8'hEE, 2'd1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, (AW)'(i));

    // Restart with a concurrent write, then full reload (fetch addr 1 throughout)
    cycle(1, 0, 8'h00, 2'd1);
    cycle(0, 1, 8'hAA, 2'd1);
    cycle(0, 1, 8'hBB, 2'd1);
    cycle(1, 1, 8'hCC, 2'd1);
    cycle(0, 0, 8'h00, 2'd1);
    for (int i = 1; i <= DEPTH; i++) cycle(0, 1, (DW)'(i), 2'd1);
    cycle(0, 0, 8'h00, 2'd1);
    cycle(0, 0, 8'h00, 2'd1);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, (AW)'(i));

    // Reset mid-load after two writes
    cycle(1, 0, 8'h00, 2'd0);
    cycle(0, 1, 8'h5A, 2'd0);
    cycle(0, 1, 8'hA5, 2'd0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 8'h00, (AW)'(i));
    cycle(0, 0, 8'h00, 2'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        d = (DW)'($urandom);
        cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 7), d,
              (AW)'($urandom_range(0, DEPTH - 1)));
      end
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 8'h00, (AW)'(i % DEPTH));

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DEPTH, default 4, is the number of program memory words; it SHALL be a power of two, at least 2.
REQ-002 Parameter AW, default 2, is the address width; it SHALL equal log2(DEPTH).
REQ-003 Parameter DW, default 8, is the instruction width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port load_start, input, 1 bit: request to begin or restart a program load; sampled each cycle.
REQ-007 Port wr_data, input, DW bits: instruction word offered by the loader source.
REQ-008 Port wr_valid, input, 1 bit: wr_data is valid.
REQ-009 Port wr_ready, output, 1 bit: the block accepts wr_data this cycle.
REQ-010 Port address, input, AW bits: processor fetch address.
REQ-011 Port instruction, output, DW bits: registered fetch data returned to the processor.
REQ-012 Port cpu_hold, output, 1 bit: the processor SHALL NOT advance while this is high.
REQ-013 Port load_done, output, 1 bit: one-cycle pulse when a load completes.
REQ-014 Port words_loaded, output, AW+1 bits: count of words written in the current or most recent load.

Function
REQ-015 Memory SHALL be DEPTH x DW registers, written only through the wr_valid/wr_ready handshake.
REQ-016 FSM states SHALL be IDLE, LOAD and DONE.
REQ-017 In IDLE, load_start=1 SHALL cause a transition to LOAD on the next edge, clearing the write pointer and words_loaded to 0 on that edge.
REQ-018 In LOAD, wr_ready SHALL be 1 and cpu_hold SHALL be 1; in IDLE and DONE, wr_ready SHALL be 0.
REQ-019 A write is accepted on an edge where wr_valid=1 and wr_ready=1: mem[ptr] <= wr_data, ptr increments, and words_loaded increments.
REQ-020 A write accepted while ptr=DEPTH-1 SHALL transition the FSM to DONE; ptr wraps to 0 and words_loaded becomes DEPTH (no saturation beyond DEPTH).
REQ-021 DONE SHALL last exactly one cycle with load_done=1 and cpu_hold=1, then return to IDLE unconditionally.
REQ-022 load_start=1 in LOAD SHALL restart the load: ptr and words_loaded clear to 0 and any wr_valid in that same cycle is not written. Load_start has priority over the write.
REQ-023 load_start=1 in DONE SHALL be ignored.
REQ-024 Previously written words at indices >= ptr SHALL retain their old contents during a partial or restarted load.
REQ-025 In IDLE, instruction SHALL update each edge to mem[address]: 1-cycle read latency, with the address sampled on that edge.
REQ-026 In LOAD and DONE, instruction SHALL be driven to 0 (NOP) on each edge.
REQ-027 A write and an IDLE read SHALL never coincide, since writes occur only in LOAD; no bypass logic is required.
REQ-028 cpu_hold SHALL be a registered decode of the FSM state, with no combinational path from inputs.

Reset
REQ-029 On rst_n=0, asynchronously:
- state=IDLE, ptr=0, words_loaded=0
- all memory words=0
- instruction=0, wr_ready=0, cpu_hold=0, load_done=0
REQ-030 Reset asserted mid-load SHALL abandon the load; after release, the block is in IDLE with all memory words 0.
REQ-031 The first edge after rst_n deasserts SHALL be treated as a normal edge, with no extra idle cycle.

Verification
REQ-032 Reset then read: rst_n low, then high, address=2 -> instruction=0x00 one edge later; cpu_hold=0, wr_ready=0.
REQ-033 Full load: pulse load_start, then present 0x11, 0x22, 0x33, 0x44 with wr_valid held high ->
- wr_ready=1 for 4 cycles
- load_done pulses 1 cycle after the 0x44 write; words_loaded=4
- back in IDLE, address=0..3 returns 0x11..0x44, each with 1-cycle latency
REQ-034 Stalled source: during LOAD, wr_valid toggles 1,0,0,1 -> only 2 words written, words_loaded=2, FSM stays in LOAD with cpu_hold=1.
REQ-035 Restart: after 0xAA and 0xBB are written, assert load_start together with wr_valid carrying 0xCC -> 0xCC not written, words_loaded=0. Then load 0x01..0x04 -> memory holds 0x01..0x04.
REQ-036 Fetch during load: address=1 throughout LOAD and DONE -> instruction=0x00; the first IDLE edge returns the new mem[1].
REQ-037 Reset mid-load: drop rst_n after 2 writes -> all outputs 0 immediately; after release, reads at addresses 0..3 return 0x00.
